commit_trace_streamer: RTL and testbench

//  Captures one 128-bit commit record {PCValue, WriteData, HiOUT, LoOUT} per committed

---
 rtl/commit_trace_streamer.sv | 128 ++++++++++++
 tb/tb_commit_trace_streamer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_streamer.sv
// Commit record capture FIFO for the pipelined MIPS core.
// Each 128-bit record {PC, WriteData, HI, LO} is streamed out as four 32-bit words over valid/ready.
module commit_trace_streamer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              CommitValid,
  input  logic [31:0]       PCValue,
  input  logic [31:0]       WriteData,
  input  logic [31:0]       HiOUT,
  input  logic [31:0]       LoOUT,
  output logic [31:0]       TraceData,
  output logic              TraceValid,
  output logic              TraceLast,
  input  logic              TraceReady,
  output logic [ADDR_W:0]   Count,
  output logic              Full,
  output logic              Empty,
  output logic [15:0]       DropCount
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned REC_W = 128;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_W0   = 3'd1,
    S_W1   = 3'd2,
    S_W2   = 3'd3,
    S_W3   = 3'd4
  } state_e;

  state_e             state_q;
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic [15:0]        drop_q, drop_d;

  logic [REC_W-1:0]   mem [DEPTH];
  logic [REC_W-1:0]   rd_rec;

  logic               handshake;
  logic               pop;
  logic               push;
  logic               drop;

  assign handshake = (state_q != S_IDLE) && TraceReady;
  assign pop       = (state_q == S_W3) && TraceReady;
  // A full FIFO still accepts a record when the head is leaving on the same edge.
  assign push      = CommitValid && (!full_q || pop);
  assign drop      = CommitValid && full_q && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    drop_d   = drop_q;
    if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    if (drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == CNT_W'(0));
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      drop_q   <= drop_d;
    end
  end

  // Word sequencer; IDLE exit looks at the registered count only.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (count_q != CNT_W'(0)) state_q <= S_W0;
        S_W0:   if (handshake) state_q <= S_W1;
        S_W1:   if (handshake) state_q <= S_W2;
        S_W2:   if (handshake) state_q <= S_W3;
        S_W3:   if (handshake) state_q <= (count_q > CNT_W'(1)) ? S_W0 : S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Record storage carries no reset; contents are don't-care until written.
  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr_q] <= {PCValue, WriteData, HiOUT, LoOUT};
  end

  assign rd_rec = mem[rd_ptr_q];

  always_comb begin
    TraceData = 32'd0;
    case (state_q)
      S_W0:    TraceData = rd_rec[127:96];
      S_W1:    TraceData = rd_rec[95:64];
      S_W2:    TraceData = rd_rec[63:32];
      S_W3:    TraceData = rd_rec[31:0];
      default: TraceData = 32'd0;
    endcase
  end

  assign TraceValid = (state_q != S_IDLE);
  assign TraceLast  = (state_q == S_W3);
  assign Count      = count_q;
  assign Full       = full_q;
  assign Empty      = empty_q;
  assign DropCount  = drop_q;

endmodule

// File: tb/tb_commit_trace_streamer.sv
// Directed bench for commit_trace_streamer: reset, single record, backpressure,
// overflow, push at full during pop, and pointer wrap.
module tb_commit_trace_streamer;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        CommitValid = 1'b0;
  logic [31:0] PCValue = '0, WriteData = '0, HiOUT = '0, LoOUT = '0;
  logic [31:0] TraceData;
  logic        TraceValid, TraceLast;
  logic        TraceReady = 1'b0;
  logic [4:0]  Count;
  logic        Full, Empty;
  logic [15:0] DropCount;

  int checks = 0;
  int errors = 0;

  commit_trace_streamer #(.DEPTH(16), .ADDR_W(4)) dut (
    .Clk(Clk), .Rst(Rst), .CommitValid(CommitValid),
    .PCValue(PCValue), .WriteData(WriteData), .HiOUT(HiOUT), .LoOUT(LoOUT),
    .TraceData(TraceData), .TraceValid(TraceValid), .TraceLast(TraceLast),
    .TraceReady(TraceReady), .Count(Count), .Full(Full), .Empty(Empty),
    .DropCount(DropCount)
  );

  always #5 Clk = ~Clk;

  function automatic logic [127:0] rec(input int i);
    logic [31:0] u;
    u = 32'(i);
    return {32'h0040_0000 + (u << 2), u ^ 32'hA5A5_0000, ~u, u + 32'h0000_1000};
  endfunction

  function automatic logic [31:0] word_of(input logic [127:0] r, input int w);
    case (w)
      0: return r[127:96];
      1: return r[95:64];
      2: return r[63:32];
      default: return r[31:0];
    endcase
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    CommitValid = 1'b0;
    TraceReady  = 1'b0;
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
  endtask

  task automatic push_rec(input logic [127:0] r);
    CommitValid = 1'b1;
    {PCValue, WriteData, HiOUT, LoOUT} = r;
    tick();
    CommitValid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (TraceValid !== 1'b0 || TraceLast !== 1'b0 || TraceData !== 32'd0 || Count !== 5'd0 ||
        Empty !== 1'b1 || Full !== 1'b0 || DropCount !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b last=%b data=%h count=%0d empty=%b full=%b drop=%0d, need 0 0 0 0 1 0 0",
               TraceValid, TraceLast, TraceData, Count, Empty, Full, DropCount);
    end
    for (int i = 0; i < 3; i++) push_rec(rec(i));
    tick();
    checks++;
    if (TraceValid !== 1'b1 || Count !== 5'd3) begin
      errors++;
      $display("FAIL reset_prestream: valid=%b count=%0d, need 1 3", TraceValid, Count);
    end
    #2 Rst = 1'b1;
    #1;
    checks++;
    if (TraceValid !== 1'b0 || Count !== 5'd0 || Empty !== 1'b1 || DropCount !== 16'd0 || TraceData !== 32'd0) begin
      errors++;
      $display("FAIL reset_async: valid=%b count=%0d empty=%b drop=%0d data=%h, need 0 0 1 0 0",
               TraceValid, Count, Empty, DropCount, TraceData);
    end
    tick();
    Rst = 1'b0;
    checks++;
    if (TraceValid !== 1'b0 || Count !== 5'd0 || Empty !== 1'b1) begin
      errors++;
      $display("FAIL reset_next_cycle: valid=%b count=%0d empty=%b, need 0 0 1", TraceValid, Count, Empty);
    end
  endtask

  task automatic test_single();
    logic [31:0] exp_w [4];
    exp_w[0] = 32'h4; exp_w[1] = 32'hA; exp_w[2] = 32'h1; exp_w[3] = 32'h2;
    do_reset();
    TraceReady = 1'b1;
    push_rec({32'h4, 32'hA, 32'h1, 32'h2});
    checks++;
    if (TraceValid !== 1'b0 || Count !== 5'd1 || Empty !== 1'b0) begin
      errors++;
      $display("FAIL single_latency: valid=%b count=%0d empty=%b, need 0 1 0", TraceValid, Count, Empty);
    end
    tick();
    for (int w = 0; w < 4; w++) begin
      checks++;
      if (TraceValid !== 1'b1 || TraceData !== exp_w[w] || TraceLast !== (w == 3)) begin
        errors++;
        $display("FAIL single_word%0d: valid=%b data=%h last=%b, need 1 %h %b",
                 w, TraceValid, TraceData, TraceLast, exp_w[w], (w == 3));
      end
      tick();
    end
    checks++;
    if (TraceValid !== 1'b0 || Empty !== 1'b1 || Count !== 5'd0) begin
      errors++;
      $display("FAIL single_done: valid=%b empty=%b count=%0d, need 0 1 0", TraceValid, Empty, Count);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    push_rec({32'h4, 32'hA, 32'h1, 32'h2});
    tick();
    TraceReady = 1'b1;
    tick();
    TraceReady = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (TraceValid !== 1'b1 || TraceData !== 32'hA || TraceLast !== 1'b0 || Count !== 5'd1) begin
        errors++;
        $display("FAIL backpressure_hold%0d: valid=%b data=%h last=%b count=%0d, need 1 0000000a 0 1",
                 c, TraceValid, TraceData, TraceLast, Count);
      end
      tick();
    end
    TraceReady = 1'b1;
    tick();
    checks++;
    if (TraceData !== 32'h1) begin
      errors++;
      $display("FAIL backpressure_resume: data=%h, need 00000001", TraceData);
    end
    tick();
    checks++;
    if (TraceData !== 32'h2 || TraceLast !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_last: data=%h last=%b, need 00000002 1", TraceData, TraceLast);
    end
    tick();
    checks++;
    if (Empty !== 1'b1 || TraceValid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_done: empty=%b valid=%b, need 1 0", Empty, TraceValid);
    end
    TraceReady = 1'b0;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 18; i++) push_rec(rec(i));
    checks++;
    if (Full !== 1'b1 || Count !== 5'd16 || DropCount !== 16'd2 || Empty !== 1'b0) begin
      errors++;
      $display("FAIL overflow_state: full=%b count=%0d drop=%0d empty=%b, need 1 16 2 0",
               Full, Count, DropCount, Empty);
    end
    TraceReady = 1'b1;
    for (int r = 0; r < 16; r++) begin
      for (int w = 0; w < 4; w++) begin
        checks++;
        if (TraceValid !== 1'b1 || TraceData !== word_of(rec(r), w) || TraceLast !== (w == 3)) begin
          errors++;
          $display("FAIL overflow_drain r%0d w%0d: valid=%b data=%h last=%b, need 1 %h %b",
                   r, w, TraceValid, TraceData, TraceLast, word_of(rec(r), w), (w == 3));
        end
        tick();
      end
    end
    checks++;
    if (Empty !== 1'b1 || TraceValid !== 1'b0 || DropCount !== 16'd2) begin
      errors++;
      $display("FAIL overflow_done: empty=%b valid=%b drop=%0d, need 1 0 2", Empty, TraceValid, DropCount);
    end
    TraceReady = 1'b0;
  endtask

  task automatic test_full_push();
    int id;
    do_reset();
    for (int i = 1; i <= 16; i++) push_rec(rec(i));
    TraceReady = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (TraceLast !== 1'b1 || Full !== 1'b1) begin
      errors++;
      $display("FAIL fullpush_at_w3: last=%b full=%b, need 1 1", TraceLast, Full);
    end
    push_rec(rec(100));
    checks++;
    if (Count !== 5'd16 || Full !== 1'b1 || DropCount !== 16'd0) begin
      errors++;
      $display("FAIL fullpush_accept: count=%0d full=%b drop=%0d, need 16 1 0", Count, Full, DropCount);
    end
    for (int r = 0; r < 16; r++) begin
      id = (r < 15) ? r + 2 : 100;
      for (int w = 0; w < 4; w++) begin
        checks++;
        if (TraceValid !== 1'b1 || TraceData !== word_of(rec(id), w)) begin
          errors++;
          $display("FAIL fullpush_drain r%0d w%0d: valid=%b data=%h, need 1 %h",
                   r, w, TraceValid, TraceData, word_of(rec(id), w));
        end
        tick();
      end
    end
    checks++;
    if (Empty !== 1'b1 || DropCount !== 16'd0) begin
      errors++;
      $display("FAIL fullpush_done: empty=%b drop=%0d, need 1 0", Empty, DropCount);
    end
    TraceReady = 1'b0;
  endtask

  task automatic test_wrap();
    int words;
    int bad;
    words = 0;
    bad = 0;
    do_reset();
    TraceReady = 1'b1;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          push_rec(rec(200 + i));
          tick(); tick(); tick();
        end
      end
      begin
        for (int c = 0; c < 2000 && words < 160; c++) begin
          tick();
          if (TraceValid === 1'b1) begin
            if (TraceData !== word_of(rec(200 + words / 4), words % 4) || TraceLast !== ((words % 4) == 3)) begin
              if (bad < 8)
                $display("FAIL wrap_word%0d: data=%h last=%b, need %h %b", words, TraceData, TraceLast,
                         word_of(rec(200 + words / 4), words % 4), ((words % 4) == 3));
              bad++;
            end
            words++;
          end
        end
      end
    join
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (words != 160) begin
      errors++;
      $display("FAIL wrap_count: words=%0d, need 160", words);
    end
    tick(); tick();
    checks++;
    if (Empty !== 1'b1 || DropCount !== 16'd0 || TraceValid !== 1'b0) begin
      errors++;
      $display("FAIL wrap_done: empty=%b drop=%0d valid=%b, need 1 0 0", Empty, DropCount, TraceValid);
    end
    TraceReady = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_full_push();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
